// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: on a miss, fills one 8-word block of the data array
// from pipelined main memory and writes the tag when the block is full.
module cache_fill_ctrl #(
   parameter int NUM_WORDS  = 8,
   parameter int NUM_BLOCKS = 128
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  miss_detected,
   input  logic [15:0]           miss_address,
   input  logic                  mem_data_valid,
   input  logic [15:0]           mem_data_in,
   output logic                  fsm_busy,
   output logic                  mem_read,
   output logic [15:0]           mem_address,
   output logic                  data_write,
   output logic [NUM_BLOCKS-1:0] block_enable,
   output logic [NUM_WORDS-1:0]  word_enable,
   output logic [15:0]           data_out,
   output logic                  tag_write,
   output logic [4:0]            tag_out,
   output logic                  fill_done
);

   typedef enum logic {
      IDLE,
      FILL
   } state_t;

   state_t      state_q, state_d;
   logic [11:0] base_q, base_d;
   logic [3:0]  iss_cnt, iss_d;
   logic [2:0]  rcv_cnt, rcv_d;
   logic        rcv_done, done_d;

   logic filling;
   logic issue;
   logic accept;
   logic last;

   assign filling = (state_q == FILL);
   assign issue   = filling && !iss_cnt[3];
   // Only words already requested can be returned; anything else is noise.
   assign accept  = filling && mem_data_valid &&
                    ({rcv_done, rcv_cnt} < iss_cnt);
   assign last    = accept && (rcv_cnt == 3'd7);

   assign fsm_busy     = filling;
   assign mem_read     = issue;
   assign mem_address  = issue ? {base_q, iss_cnt[2:0], 1'b0} : 16'h0000;
   assign data_write   = accept;
   assign word_enable  = accept ? (NUM_WORDS'(1) << rcv_cnt) : '0;
   assign block_enable = accept ? (NUM_BLOCKS'(1) << base_q[6:0]) : '0;
   assign data_out     = accept ? mem_data_in : 16'h0000;
   assign tag_write    = last;
   assign fill_done    = last;
   assign tag_out      = base_q[11:7];

   // Next-state: latch the block on a miss, then run issue and receive
   // counters independently until the eighth word has been accepted.
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      iss_d   = iss_cnt;
      rcv_d   = rcv_cnt;
      done_d  = rcv_done;
      unique case (state_q)
         IDLE: begin
            if (miss_detected) begin
               state_d = FILL;
               base_d  = miss_address[15:4];
               iss_d   = 4'd0;
               rcv_d   = 3'd0;
               done_d  = 1'b0;
            end
         end
         FILL: begin
            if (issue) begin
               iss_d = iss_cnt + 4'd1;
            end
            if (accept) begin
               rcv_d = rcv_cnt + 3'd1;
               if (last) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and counter registers; reset abandons any fill in progress.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         base_q   <= 12'h000;
         iss_cnt  <= 4'd0;
         rcv_cnt  <= 3'd0;
         rcv_done <= 1'b0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         iss_cnt  <= iss_d;
         rcv_cnt  <= rcv_d;
         rcv_done <= done_d;
      end
   end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: table-driven fills, reset and spurious
// input sequences, then random fills against a fill-level model.
module tb_cache_fill_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         miss_detected;
   logic [15:0]  miss_address;
   logic         mem_data_valid;
   logic [15:0]  mem_data_in;
   logic         fsm_busy;
   logic         mem_read;
   logic [15:0]  mem_address;
   logic         data_write;
   logic [127:0] block_enable;
   logic [7:0]   word_enable;
   logic [15:0]  data_out;
   logic         tag_write;
   logic [4:0]   tag_out;
   logic         fill_done;

   cache_fill_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .miss_detected  (miss_detected),
      .miss_address   (miss_address),
      .mem_data_valid (mem_data_valid),
      .mem_data_in    (mem_data_in),
      .fsm_busy       (fsm_busy),
      .mem_read       (mem_read),
      .mem_address    (mem_address),
      .data_write     (data_write),
      .block_enable   (block_enable),
      .word_enable    (word_enable),
      .data_out       (data_out),
      .tag_write      (tag_write),
      .tag_out        (tag_out),
      .fill_done      (fill_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [15:0] data;
   } resp_t;

   typedef struct {
      logic [15:0] addr;
      int          lat;
      int          gap_after;
      int          gap_len;
      bit          hold;
      int          blk;
      int          tag;
      int          rel;
      logic [15:0] d0;
   } vec_t;

   resp_t       rq[$];
   vec_t        tbl[7];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          lat = 4;
   int          gap_after = -1;
   int          gap_len = 0;
   int          gap_left = 0;
   int          spur = 0;
   int          stall = 0;
   bit          m_busy = 1'b0;
   logic [15:0] m_base = 16'h0000;
   logic [15:0] doff = 16'h0000;
   int          m_blk = 0;
   int          m_tag = 0;
   int          m_req = 0;
   int          m_wr = 0;
   int          done_cyc = 0;

   function automatic void chk(string nm, logic [127:0] act,
                               logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endfunction

   // One clock cycle: memory model drives returns, outputs are checked
   // against the fill model, then the model advances.
   task automatic tick(input bit miss, input logic [15:0] addr);
      bit          gen;
      bit          lst;
      logic [15:0] rdat;
      resp_t       r;
      @(posedge clk);
      #1;
      cyc++;
      miss_detected  = miss;
      miss_address   = addr;
      mem_data_valid = 1'b0;
      mem_data_in    = 16'($urandom);
      gen  = 1'b0;
      rdat = 16'h0000;
      if (gap_left > 0) begin
         gap_left--;
      end else if (rq.size() > 0 && rq[0].due <= cyc &&
                   !(stall != 0 && $urandom_range(0, 3) == 0)) begin
         gen  = 1'b1;
         rdat = rq[0].data;
         void'(rq.pop_front());
         mem_data_valid = 1'b1;
         mem_data_in    = rdat;
      end else if (rq.size() == 0 &&
                   (spur == 2 || (spur == 1 && $urandom_range(0, 3) == 0))) begin
         mem_data_valid = 1'b1;
      end
      #1;
      chk("busy", fsm_busy, m_busy);
      chk("mem_read", mem_read, m_busy && m_req < 8);
      if (mem_read) begin
         chk("mem_address", mem_address, m_base + 16'(2 * m_req));
         r.due  = cyc + lat;
         r.data = doff + 16'(mem_address[3:1]);
         rq.push_back(r);
         m_req++;
      end
      lst = gen && (m_wr == 7);
      chk("data_write", data_write, gen);
      chk("word_enable", word_enable, gen ? (128'(1) << m_wr) : 128'(0));
      chk("block_enable", block_enable, gen ? (128'(1) << m_blk) : 128'(0));
      if (gen) chk("data_out", data_out, rdat);
      chk("tag_write", tag_write, lst);
      chk("fill_done", fill_done, lst);
      if (lst) begin
         chk("tag_out", tag_out, m_tag);
         done_cyc = cyc;
      end
      if (gen) begin
         m_wr++;
         if (m_wr == gap_after) gap_left = gap_len;
      end
      if (lst) begin
         m_busy = 1'b0;
      end else if (!m_busy && miss) begin
         m_busy = 1'b1;
         m_base = {addr[15:4], 4'h0};
         m_req  = 0;
         m_wr   = 0;
      end
   endtask

   task automatic run_fill(input logic [15:0] addr, input int l,
                           input int ga, input int gl, input bit hold,
                           input int blk, input int tg, input int rel,
                           input logic [15:0] d0);
      int c0;
      lat       = l;
      gap_after = ga;
      gap_len   = gl;
      gap_left  = 0;
      doff      = d0;
      m_blk     = blk;
      m_tag     = tg;
      tick(1'b1, addr);
      c0 = cyc;
      for (int k = 0; k < 300 && m_busy; k++) tick(hold, addr);
      if (m_busy) begin
         chk("fill_timeout", m_busy, 1'b0);
         m_busy = 1'b0;
         rq.delete();
      end else if (rel >= 0) begin
         chk("done_cycle", done_cyc - c0, rel);
      end
   endtask

   task automatic chk_all_zero();
      chk("rst_busy", fsm_busy, 1'b0);
      chk("rst_mem_read", mem_read, 1'b0);
      chk("rst_mem_address", mem_address, 16'h0);
      chk("rst_data_write", data_write, 1'b0);
      chk("rst_block_enable", block_enable, 128'h0);
      chk("rst_word_enable", word_enable, 8'h0);
      chk("rst_data_out", data_out, 16'h0);
      chk("rst_tag_write", tag_write, 1'b0);
      chk("rst_tag_out", tag_out, 5'h0);
      chk("rst_fill_done", fill_done, 1'b0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] a;
      int          idle;
      tbl[0] = '{16'h1A36, 4, -1, 0, 1'b0, 35, 3, 12, 16'hA000};
      tbl[1] = '{16'h2468, 4, 4, 3, 1'b0, 70, 4, 15, 16'hB100};
      tbl[2] = '{16'h0000, 2, -1, 0, 1'b0, 0, 0, 10, 16'hC200};
      tbl[3] = '{16'hFFFE, 1, -1, 0, 1'b0, 127, 31, 9, 16'hD300};
      tbl[4] = '{16'h0040, 4, -1, 0, 1'b1, 4, 0, 12, 16'hE400};
      tbl[5] = '{16'h0850, 4, -1, 0, 1'b0, 5, 1, 12, 16'hF500};
      tbl[6] = '{16'h7FF8, 6, -1, 0, 1'b0, 127, 15, 14, 16'h1600};

      rst            = 1'b0;
      miss_detected  = 1'b1;
      miss_address   = 16'h1234;
      mem_data_valid = 1'b1;
      mem_data_in    = 16'hBEEF;
      #12;
      chk_all_zero();
      miss_detected  = 1'b0;
      mem_data_valid = 1'b0;
      rst            = 1'b1;

      for (int i = 0; i < 7; i++) begin
         run_fill(tbl[i].addr, tbl[i].lat, tbl[i].gap_after,
                  tbl[i].gap_len, tbl[i].hold, tbl[i].blk, tbl[i].tag,
                  tbl[i].rel, tbl[i].d0);
      end

      spur = 2;
      for (int k = 0; k < 4; k++) tick(1'b0, 16'h1234);
      spur = 0;

      lat       = 3;
      gap_after = -1;
      gap_left  = 0;
      doff      = 16'h5500;
      m_blk     = 65;
      m_tag     = 7;
      tick(1'b1, 16'h3C12);
      for (int k = 0; k < 100 && m_wr < 3; k++) tick(1'b0, 16'h0000);
      rst = 1'b0;
      #1;
      chk_all_zero();
      m_busy   = 1'b0;
      m_wr     = 0;
      gap_left = 0;
      rq.delete();
      tick(1'b0, 16'h0000);
      tick(1'b0, 16'h0000);
      rst = 1'b1;
      run_fill(16'h3C12, 3, -1, 0, 1'b0, 65, 7, 11, 16'h5500);

      spur  = 1;
      stall = 1;
      for (int n = 0; n < 40; n++) begin
         a    = 16'($urandom);
         idle = $urandom_range(0, 2);
         for (int k = 0; k < idle; k++) tick(1'b0, 16'($urandom));
         run_fill(a, $urandom_range(1, 6), -1, 0,
                  1'($urandom_range(0, 1)), int'(a[10:4]),
                  int'(a[15:11]), -1, 16'($urandom));
      end
      tick(1'b0, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Miss-handling controller that fills one block of the 128-block × 8-word data array from main memory. On a miss it issues eight sequential word reads, collects the returned data, and writes each word into the selected block. It drives the array's one-hot block/word enables and the tag write strobe. It sits between the cache hit logic and the pipelined main memory, one instance per cache (I and D).

## Interface
Parameters:
- NUM_WORDS, 8, words per block; the enable and counter widths below assume 8.
- NUM_BLOCKS, 128, blocks in the data array; the block_enable width assumes 128.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset: asynchronous, active-low.
- miss_detected  in  1  the cache missed this cycle; sampled only in IDLE.
- miss_address  in  16  byte address of the missing access.
- mem_data_valid  in  1  mem_data_in holds the next returned word.
- mem_data_in  in  16  read data from main memory.
- fsm_busy  out  1  a fill is in progress; stalls the pipeline stage.
- mem_read  out  1  read request to memory this cycle.
- mem_address  out  16  word-aligned byte address of the request.
- data_write  out  1  write strobe to the data array.
- block_enable  out  128  one-hot block select.
- word_enable  out  8  one-hot word select.
- data_out  out  16  word to write; equals mem_data_in.
- tag_write  out  1  write strobe for the tag/valid entry of the filled block.
- tag_out  out  5  tag written on tag_write.
- fill_done  out  1  one-cycle pulse when the fill completes.

## Operation
- Address split:
  - tag = addr[15:11]
  - index = addr[10:4]
  - word = addr[3:1]
  - addr[0] is ignored.
- States:
  - IDLE: fsm_busy=0. If miss_detected=1:
    - latch base = {miss_address[15:4],4'b0} and tag = miss_address[15:11];
    - clear iss_cnt and rcv_cnt;
    - go to FILL.
  - FILL: fsm_busy=1.
    - Issue side: while iss_cnt<8, drive mem_read=1 and mem_address = base + 2·iss_cnt, then increment iss_cnt. mem_read=0 once iss_cnt=8.
    - Receive side: each cycle with mem_data_valid=1 and rcv_cnt<iss_cnt:
      - data_write=1, word_enable = 1<<rcv_cnt, data_out = mem_data_in;
      - increment rcv_cnt.
    - Completion: when a valid is accepted with rcv_cnt=7, assert tag_write=1 and fill_done=1 in that same cycle, then go to IDLE.
- block_enable = 1<<base[10:4] whenever data_write=1; otherwise all zero.
- word_enable is all zero when data_write=0.
- Data arrives in request order, so the word order is fixed at 0..7. The original miss word gets no priority.
- iss_cnt is 4 bits (0..8). rcv_cnt is 3 bits plus a done flag. base + 2·iss_cnt never carries past addr[3:0].

Boundary behaviour:
- miss_detected while in FILL, including the completion cycle: ignored. The hit logic re-raises it after fsm_busy falls.
- mem_data_valid in IDLE, or with rcv_cnt ≥ iss_cnt: ignored, no write.
- A request issue and a data receive in the same cycle are both allowed.
- Reset asserted mid-fill: immediately go to IDLE and clear all counters and outputs. The partially written block keeps its words, but no tag_write occurs, so the entry stays invalid.

## Timing
- Reset values: every output is 0 and the state is IDLE.
- Outputs:
  - fsm_busy is registered (state==FILL).
  - mem_read and mem_address are decoded from registered state/iss_cnt.
  - data_write, word_enable, block_enable, data_out, tag_write and fill_done are combinational from mem_data_valid and the registered counters.
  - The data array captures writes on the next rising edge.
- Miss sampled at edge E0. FILL starts in cycle 1, and requests are issued in cycles 1..8 back-to-back.
- With a memory that returns data L cycles after a request:
  - writes land in cycles 1+L .. 8+L;
  - fill_done and tag_write occur in cycle 8+L;
  - fsm_busy deasserts in cycle 9+L.
- For L=4, a fill occupies 12 cycles of fsm_busy.
- Minimum gap between two fills: one IDLE cycle.

## Test plan
- Basic fill: miss_address=0x1A36, memory with L=4 returning 0xA000+i.
  - Requests go to 0x1A30, 0x1A32, …, 0x1A3E.
  - block_enable bit 35 only; word_enable steps 0x01→0x80.
  - data_out runs 0xA000..0xA007.
  - tag_write with tag_out=3 in cycle 12; fsm_busy falls in cycle 13.
- Gapped return: mem_data_valid deasserted for 3 cycles between words 3 and 4.
  - No write during the gap; words still land in order.
  - fill_done only after the 8th valid.
- Spurious inputs:
  - mem_data_valid pulsed in IDLE → no data_write.
  - miss_detected=1 held throughout a fill → exactly one fill, and the second fill starts one cycle after fsm_busy falls.
- Reset mid-fill: drive rst=0 after the 3rd accepted word.
  - All outputs are 0 asynchronously, and tag_write never fires.
  - A new miss after reset release fills the full block correctly.
- Index extremes: misses at 0x0000 (block 0, tag 0) and 0xFFFE (block 127, tag 31).
  - block_enable is exactly bit 0 or bit 127 respectively.
  - Addresses never leave the block: 0xFFF0..0xFFFE.
- Back-to-back fills: miss 0x0040, then miss 0x0850 in the first IDLE cycle.
  - Blocks 4 and 5 fill in turn, with tags 0 and 1.
  - There is no overlap of data_write between the two fills.
